// File: rtl/pipeline_hazard_unit.sv
// Stall/flush and redirect controller for an in-order pipeline.
// Stage 0 is fetch, 1 is decode, 2 is exec and the last stage is writeback.
// Combinational stall/flush vectors are built from per-stage busy flags,
// load-use hazards and redirects. A small FSM keeps a redirect alive while
// fetch cannot accept it. A shift-register scoreboard tracks loads that
// have left exec but whose data cannot be forwarded yet.
module pipeline_hazard_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_STAGES     = 5,
    parameter int LOAD_LAT       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic [NUM_STAGES-1:0]     stage_busy,
    input  logic                      regfile_stall,
    input  logic                      dec_rs_enable,
    input  logic [REG_ADDR_WIDTH:0]   dec_rs_addr,
    input  logic                      dec_rt_enable,
    input  logic [REG_ADDR_WIDTH:0]   dec_rt_addr,
    input  logic                      dec_branch,
    input  logic                      exec_wb_reg,
    input  logic                      exec_mem_enable,
    input  logic [REG_ADDR_WIDTH:0]   exec_write_addr,
    input  logic                      exec_take_branch,
    input  logic [ADDR_WIDTH-1:0]     exec_branch_target,
    input  logic                      trap_req,
    input  logic [ADDR_WIDTH-1:0]     trap_target,
    output logic [NUM_STAGES-1:0]     stall,
    output logic [NUM_STAGES-1:0]     flush,
    output logic                      fetch_branch,
    output logic [ADDR_WIDTH-1:0]     fetch_branch_target,
    output logic                      redirect_pending
);

    localparam int PA_W = REG_ADDR_WIDTH + 1;
    // Scoreboard depth; a one-entry dummy is kept when LOAD_LAT is 1 so the
    // hazard logic has a uniform shape.
    localparam int SB_N = LOAD_LAT - 1;
    localparam int SB_D = (SB_N > 0) ? SB_N : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  latch_q, latch_d;
    logic                   discard_q;
    logic [SB_D-1:0]        sb_v_q;
    logic [PA_W-1:0]        sb_a_q [SB_D];

    logic                   redir;
    logic [ADDR_WIDTH-1:0]  tgt;
    logic                   exec_load;
    logic                   rs_hit, rt_hit, loaduse;
    logic                   hold;
    logic [NUM_STAGES-1:0]  stall_c, flush_c;

    assign redir     = trap_req | exec_take_branch;
    assign tgt       = trap_req ? trap_target : exec_branch_target;
    assign exec_load = exec_wb_reg & exec_mem_enable;
    assign hold      = (state_q == S_HOLD);

    // Load-use detection against the load in exec and pending scoreboard loads.
    always_comb begin
        rs_hit = exec_load && (exec_write_addr == dec_rs_addr);
        rt_hit = exec_load && (exec_write_addr == dec_rt_addr);
        for (int k = 0; k < SB_D; k++) begin
            if (sb_v_q[k] && (sb_a_q[k] == dec_rs_addr)) rs_hit = 1'b1;
            if (sb_v_q[k] && (sb_a_q[k] == dec_rt_addr)) rt_hit = 1'b1;
        end
        loaduse = (dec_rs_enable && rs_hit && (dec_rs_addr != '0)) ||
                  (dec_rt_enable && rt_hit && (dec_rt_addr != '0));
    end

    // Per-stage stall/flush; a stall propagates upstream from the first busy stage.
    always_comb begin
        stall_c = '0;
        flush_c = '0;
        stall_c[NUM_STAGES-1] = stage_busy[NUM_STAGES-1];
        flush_c[NUM_STAGES-1] = stage_busy[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 3; i--) begin
            stall_c[i] = stage_busy[i] | stall_c[i+1];
            flush_c[i] = stage_busy[i];
        end
        stall_c[2] = stage_busy[2] | stall_c[3];
        flush_c[2] = stage_busy[2] | trap_req;
        stall_c[1] = loaduse | (dec_branch & stage_busy[0]) | stall_c[2] | regfile_stall;
        flush_c[1] = loaduse | (dec_branch & stage_busy[0]) | redir | hold;
        stall_c[0] = stage_busy[0] | stall_c[1];
        flush_c[0] = redir | stage_busy[0] | discard_q;
        if (rst || !run) begin
            stall_c = '1;
            flush_c = '1;
        end
    end

    assign stall = stall_c;
    assign flush = flush_c;

    // Redirect FSM: issue immediately when fetch is free, otherwise park the target.
    always_comb begin
        state_d             = state_q;
        latch_d             = latch_q;
        fetch_branch        = 1'b0;
        fetch_branch_target = '0;
        case (state_q)
            S_IDLE: begin
                if (redir) begin
                    if (!stall_c[0]) begin
                        fetch_branch        = 1'b1;
                        fetch_branch_target = tgt;
                    end else begin
                        state_d = S_HOLD;
                        latch_d = tgt;
                    end
                end
            end
            S_HOLD: begin
                // A trap arriving while parked replaces the older target.
                fetch_branch        = 1'b1;
                fetch_branch_target = trap_req ? trap_target : latch_q;
                latch_d             = fetch_branch_target;
                if (!stall_c[0]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            fetch_branch        = 1'b0;
            fetch_branch_target = '0;
        end
    end

    assign redirect_pending = hold & ~rst;

    // FSM state, parked target and stale-fetch discard flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            latch_q   <= '0;
            discard_q <= 1'b0;
        end else if (run) begin
            state_q <= state_d;
            latch_q <= latch_d;
            if (redir && stage_busy[0]) discard_q <= 1'b1;
            else if (!stage_busy[0])    discard_q <= 1'b0;
        end
    end

    if (SB_N > 0) begin : g_sb
        // Scoreboard valid bits shift one slot each time exec advances.
        always_ff @(posedge clk) begin
            if (rst) begin
                sb_v_q <= '0;
            end else if (run && !stall_c[2]) begin
                sb_v_q[0] <= exec_load & ~flush_c[2];
                for (int k = 1; k < SB_D; k++) sb_v_q[k] <= sb_v_q[k-1];
            end
        end

        // Scoreboard destination addresses follow the valid bits.
        always_ff @(posedge clk) begin
            if (run && !rst && !stall_c[2]) begin
                sb_a_q[0] <= exec_write_addr;
                for (int k = 1; k < SB_D; k++) sb_a_q[k] <= sb_a_q[k-1];
            end
        end
    end else begin : g_nosb
        assign sb_v_q    = '0;
        assign sb_a_q[0] = '0;
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed scenarios with literal expectations,
// then a randomized run checked against a behavioural model.
module tb_pipeline_hazard_unit;

    localparam int AW  = 32;
    localparam int RW  = 5;
    localparam int NS  = 5;
    localparam int LL  = 2;
    localparam int SBN = LL - 1;

    logic           clk = 1'b0;
    logic           rst, run;
    logic [NS-1:0]  stage_busy;
    logic           regfile_stall;
    logic           dec_rs_enable, dec_rt_enable, dec_branch;
    logic [RW:0]    dec_rs_addr, dec_rt_addr;
    logic           exec_wb_reg, exec_mem_enable, exec_take_branch;
    logic [RW:0]    exec_write_addr;
    logic [AW-1:0]  exec_branch_target;
    logic           trap_req;
    logic [AW-1:0]  trap_target;
    logic [NS-1:0]  stall, flush;
    logic           fetch_branch, redirect_pending;
    logic [AW-1:0]  fetch_branch_target;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit             m_hold, m_discard;
    logic [AW-1:0]  m_tgt;
    bit             m_sb_v [SBN];
    logic [RW:0]    m_sb_a [SBN];
    logic [NS-1:0]  e_stall, e_flush;
    logic           e_fb, e_pend;
    logic [AW-1:0]  e_tgt;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .NUM_STAGES(NS), .LOAD_LAT(LL)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .stage_busy(stage_busy),
        .regfile_stall(regfile_stall),
        .dec_rs_enable(dec_rs_enable), .dec_rs_addr(dec_rs_addr),
        .dec_rt_enable(dec_rt_enable), .dec_rt_addr(dec_rt_addr),
        .dec_branch(dec_branch),
        .exec_wb_reg(exec_wb_reg), .exec_mem_enable(exec_mem_enable),
        .exec_write_addr(exec_write_addr),
        .exec_take_branch(exec_take_branch), .exec_branch_target(exec_branch_target),
        .trap_req(trap_req), .trap_target(trap_target),
        .stall(stall), .flush(flush), .fetch_branch(fetch_branch),
        .fetch_branch_target(fetch_branch_target), .redirect_pending(redirect_pending)
    );

    task automatic clear_inputs();
        rst = 1'b0; run = 1'b1; stage_busy = '0; regfile_stall = 1'b0;
        dec_rs_enable = 1'b0; dec_rs_addr = '0; dec_rt_enable = 1'b0; dec_rt_addr = '0;
        dec_branch = 1'b0; exec_wb_reg = 1'b0; exec_mem_enable = 1'b0; exec_write_addr = '0;
        exec_take_branch = 1'b0; exec_branch_target = '0; trap_req = 1'b0; trap_target = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_flight(input logic [RW:0] a);
        for (int k = 0; k < SBN; k++)
            if (m_sb_v[k] && m_sb_a[k] == a) return 1'b1;
        if (exec_wb_reg && exec_mem_enable && exec_write_addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // Expected outputs for the current inputs and model state.
    task automatic model_eval();
        logic [NS-1:0] reason;
        logic          lu, acc, rd;
        logic [AW-1:0] t;
        lu = (dec_rs_enable && dec_rs_addr != 0 && in_flight(dec_rs_addr)) ||
             (dec_rt_enable && dec_rt_addr != 0 && in_flight(dec_rt_addr));
        rd = trap_req | exec_take_branch;
        t  = trap_req ? trap_target : exec_branch_target;
        reason    = stage_busy;
        reason[1] = lu | (dec_branch & stage_busy[0]) | regfile_stall;
        acc = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            acc = acc | reason[i];
            e_stall[i] = acc;
        end
        e_flush    = stage_busy;
        e_flush[0] = rd | stage_busy[0] | m_discard;
        e_flush[1] = lu | (dec_branch & stage_busy[0]) | rd | m_hold;
        e_flush[2] = stage_busy[2] | trap_req;
        if (rst || !run) begin
            e_stall = '1;
            e_flush = '1;
        end
        e_fb = 1'b0; e_tgt = '0;
        if (m_hold) begin
            e_fb = 1'b1; e_tgt = trap_req ? trap_target : m_tgt;
        end else if (rd && !e_stall[0]) begin
            e_fb = 1'b1; e_tgt = t;
        end
        if (rst) begin
            e_fb = 1'b0; e_tgt = '0;
        end
        e_pend = m_hold && !rst;
    endtask

    // Advance the model across a clock edge.
    task automatic model_step();
        logic rd;
        rd = trap_req | exec_take_branch;
        if (rst) begin
            m_hold = 0; m_discard = 0; m_tgt = '0;
            for (int k = 0; k < SBN; k++) m_sb_v[k] = 0;
        end else if (run) begin
            if (m_hold) begin
                if (trap_req) m_tgt = trap_target;
                if (!e_stall[0]) m_hold = 0;
            end else if (rd && e_stall[0]) begin
                m_hold = 1;
                m_tgt  = trap_req ? trap_target : exec_branch_target;
            end
            if (rd && stage_busy[0]) m_discard = 1;
            else if (!stage_busy[0]) m_discard = 0;
            if (!e_stall[2]) begin
                for (int k = SBN - 1; k > 0; k--) begin
                    m_sb_v[k] = m_sb_v[k-1]; m_sb_a[k] = m_sb_a[k-1];
                end
                m_sb_v[0] = exec_wb_reg && exec_mem_enable && !e_flush[2];
                m_sb_a[0] = exec_write_addr;
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; trap_req = 1'b1; trap_target = 32'h80; stage_busy = 5'b00101;
        next_cycle();
        next_cycle();
        checks++;
        if ({stall, flush, fetch_branch, redirect_pending} !== {5'h1f, 5'h1f, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %b exp %b",
                     {stall, flush, fetch_branch, redirect_pending}, {5'h1f, 5'h1f, 2'b00});
        end
        checks++;
        if (fetch_branch_target !== 32'h0) begin
            errors++;
            $display("FAIL reset_target: got %h exp 0", fetch_branch_target);
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_loaduse();
        logic [11:0] exp [5];
        exp[0] = {5'b00011, 5'b00010, 2'b00};
        exp[1] = {5'b00011, 5'b00010, 2'b00};
        exp[2] = {5'b00000, 5'b00000, 2'b00};
        exp[3] = {5'b00000, 5'b00000, 2'b00};
        exp[4] = {5'b00000, 5'b00000, 2'b00};
        clear_inputs();
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) begin exec_wb_reg = 1; exec_mem_enable = 1; exec_write_addr = 6'd5; end
            if (c < 3) begin dec_rs_enable = 1; dec_rs_addr = 6'd5; end
            if (c == 3) begin exec_wb_reg = 1; exec_mem_enable = 1; exec_write_addr = 6'd0; end
            if (c >= 3) begin dec_rs_enable = 1; dec_rs_addr = 6'd0; dec_rt_enable = 1; dec_rt_addr = 6'd0; end
            #1;
            checks++;
            if ({stall, flush, fetch_branch, redirect_pending} !== exp[c]) begin
                errors++;
                $display("FAIL loaduse_c%0d: got %b exp %b", c,
                         {stall, flush, fetch_branch, redirect_pending}, exp[c]);
            end
            next_cycle();
        end
        clear_inputs();
        exec_wb_reg = 1; exec_mem_enable = 1; exec_write_addr = 6'd7;
        dec_rt_enable = 1; dec_rt_addr = 6'd7;
        #1;
        checks++;
        if (stall[1] !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_rt: got stall[1]=%b exp 1", stall[1]);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_branch_idle();
        clear_inputs();
        exec_take_branch = 1; exec_branch_target = 32'h400;
        #1;
        checks++;
        if ({stall, flush, fetch_branch, redirect_pending} !== {5'b00000, 5'b00011, 1'b1, 1'b0} ||
            fetch_branch_target !== 32'h400) begin
            errors++;
            $display("FAIL branch_idle: got %b tgt %h exp %b tgt 400",
                     {stall, flush, fetch_branch, redirect_pending}, fetch_branch_target,
                     {5'b00000, 5'b00011, 2'b10});
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if ({stall, flush, fetch_branch, redirect_pending} !== 12'b0) begin
            errors++;
            $display("FAIL branch_idle_after: got %b exp 0",
                     {stall, flush, fetch_branch, redirect_pending});
        end
        next_cycle();
    endtask

    task automatic test_branch_hold();
        logic [11:0] exp [5];
        exp[0] = {5'b00001, 5'b00011, 1'b0, 1'b0};
        exp[1] = {5'b00001, 5'b00011, 1'b1, 1'b1};
        exp[2] = {5'b00001, 5'b00011, 1'b1, 1'b1};
        exp[3] = {5'b00000, 5'b00011, 1'b1, 1'b1};
        exp[4] = {5'b00000, 5'b00000, 1'b0, 1'b0};
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) begin exec_take_branch = 1; exec_branch_target = 32'h400; end
            if (c < 3) stage_busy[0] = 1'b1;
            #1;
            checks++;
            if ({stall, flush, fetch_branch, redirect_pending} !== exp[c] ||
                (fetch_branch && fetch_branch_target !== 32'h400)) begin
                errors++;
                $display("FAIL branch_hold_c%0d: got %b tgt %h exp %b tgt 400", c,
                         {stall, flush, fetch_branch, redirect_pending}, fetch_branch_target, exp[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_trap_priority();
        clear_inputs();
        trap_req = 1; trap_target = 32'h80; exec_take_branch = 1; exec_branch_target = 32'h400;
        #1;
        checks++;
        if ({stall, flush, fetch_branch, redirect_pending} !== {5'b00000, 5'b00111, 1'b1, 1'b0} ||
            fetch_branch_target !== 32'h80) begin
            errors++;
            $display("FAIL trap_priority: got %b tgt %h exp %b tgt 80",
                     {stall, flush, fetch_branch, redirect_pending}, fetch_branch_target,
                     {5'b00000, 5'b00111, 2'b10});
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp [5];
        exp[0] = {5'b00000, 5'b00000, 2'b00};
        exp[1] = {5'b01111, 5'b01000, 2'b00};
        exp[2] = {5'b01111, 5'b01000, 2'b00};
        exp[3] = {5'b00011, 5'b00010, 2'b00};
        exp[4] = {5'b00000, 5'b00000, 2'b00};
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) begin exec_wb_reg = 1; exec_mem_enable = 1; exec_write_addr = 6'd9; end
            if (c == 1 || c == 2) stage_busy[3] = 1'b1;
            if (c >= 3) begin dec_rs_enable = 1; dec_rs_addr = 6'd9; end
            #1;
            checks++;
            if ({stall, flush, fetch_branch, redirect_pending} !== exp[c]) begin
                errors++;
                $display("FAIL backpressure_c%0d: got %b exp %b", c,
                         {stall, flush, fetch_branch, redirect_pending}, exp[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_in_hold();
        logic [11:0] exp [5];
        exp[0] = {5'b00001, 5'b00011, 1'b0, 1'b0};
        exp[1] = {5'h1f, 5'h1f, 1'b1, 1'b1};
        exp[2] = {5'h1f, 5'h1f, 1'b0, 1'b0};
        exp[3] = {5'h1f, 5'h1f, 1'b0, 1'b0};
        exp[4] = {5'b00000, 5'b00000, 1'b0, 1'b0};
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) begin exec_take_branch = 1; exec_branch_target = 32'h400; end
            if (c < 4) stage_busy[0] = 1'b1;
            if (c == 1) run = 1'b0;
            if (c == 2 || c == 3) rst = 1'b1;
            #1;
            checks++;
            if ({stall, flush, fetch_branch, redirect_pending} !== exp[c] ||
                (c == 1 && fetch_branch_target !== 32'h400) ||
                (c >= 2 && fetch_branch_target !== 32'h0)) begin
                errors++;
                $display("FAIL reset_in_hold_c%0d: got %b tgt %h exp %b", c,
                         {stall, flush, fetch_branch, redirect_pending}, fetch_branch_target, exp[c]);
            end
            next_cycle();
        end
        clear_inputs();
        run = 1'b0; exec_take_branch = 1; exec_branch_target = 32'h123;
        #1;
        checks++;
        if ({stall, flush, fetch_branch, redirect_pending} !== {5'h1f, 5'h1f, 2'b00}) begin
            errors++;
            $display("FAIL run_low_idle: got %b exp %b",
                     {stall, flush, fetch_branch, redirect_pending}, {5'h1f, 5'h1f, 2'b00});
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        clear_inputs();
        rst = 1'b1;
        m_hold = 0; m_discard = 0; m_tgt = '0;
        for (int k = 0; k < SBN; k++) begin m_sb_v[k] = 0; m_sb_a[k] = '0; end
        next_cycle();
        for (int n = 0; n < 600; n++) begin
            clear_inputs();
            run              = ($urandom_range(0, 14) != 0);
            for (int i = 0; i < NS; i++) stage_busy[i] = ($urandom_range(0, 5) == 0);
            regfile_stall    = ($urandom_range(0, 9) == 0);
            dec_rs_enable    = $urandom_range(0, 1);
            dec_rs_addr      = 6'($urandom_range(0, 7));
            dec_rt_enable    = $urandom_range(0, 1);
            dec_rt_addr      = 6'($urandom_range(0, 7));
            dec_branch       = ($urandom_range(0, 4) == 0);
            exec_wb_reg      = $urandom_range(0, 1);
            exec_mem_enable  = $urandom_range(0, 1);
            exec_write_addr  = 6'($urandom_range(0, 7));
            exec_take_branch = !m_hold && ($urandom_range(0, 5) == 0);
            exec_branch_target = $urandom;
            trap_req         = ($urandom_range(0, 11) == 0);
            trap_target      = $urandom;
            #1;
            model_eval();
            checks++;
            if (stall !== e_stall) begin
                errors++;
                $display("FAIL rand_stall n=%0d: got %b exp %b", n, stall, e_stall);
            end
            checks++;
            if (flush !== e_flush) begin
                errors++;
                $display("FAIL rand_flush n=%0d: got %b exp %b", n, flush, e_flush);
            end
            checks++;
            if ({fetch_branch, fetch_branch_target} !== {e_fb, e_tgt}) begin
                errors++;
                $display("FAIL rand_redirect n=%0d: got %b/%h exp %b/%h",
                         n, fetch_branch, fetch_branch_target, e_fb, e_tgt);
            end
            checks++;
            if (redirect_pending !== e_pend) begin
                errors++;
                $display("FAIL rand_pending n=%0d: got %b exp %b", n, redirect_pending, e_pend);
            end
            @(posedge clk);
            model_step();
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_loaduse();
        test_branch_idle();
        test_branch_hold();
        test_trap_priority();
        test_back_to_back();
        test_reset_in_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
